// File: rtl/svm_multiclass_infer_ctrl_if.sv
// rtl/svm_multiclass_infer_ctrl_if.sv - memory-engine and compute-array handshake bundle
// of the SVM inference sequencer; master = sequencer, slave = memory engine / array side.
interface svm_multiclass_infer_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CLS_W      = 3
);
  logic                         mem_cmd_vld;
  logic [3:0]                   mem_cmd;
  logic [31:0]                  mem_cmd_data;
  logic [CLS_W-1:0]             mem_cmd_cls;
  logic [2:0]                   mem_resp;
  logic [31:0]                  mem_resp_data;
  logic                         mem_resp_vld;
  logic                         weights_progd;
  logic                         data_vec_progd;
  logic                         comp_start;
  logic signed [DATA_WIDTH-1:0] comp_res;
  logic                         comp_res_vld;
  logic                         clear_weights;
  logic                         clear_data_vec;
  logic                         arr_wghtbar_data;

  modport master (
    output mem_cmd_vld, mem_cmd, mem_cmd_data, mem_cmd_cls,
    output comp_start, clear_weights, clear_data_vec, arr_wghtbar_data,
    input  mem_resp, mem_resp_data, mem_resp_vld,
    input  weights_progd, data_vec_progd, comp_res, comp_res_vld
  );

  modport slave (
    input  mem_cmd_vld, mem_cmd, mem_cmd_data, mem_cmd_cls,
    input  comp_start, clear_weights, clear_data_vec, arr_wghtbar_data,
    output mem_resp, mem_resp_data, mem_resp_vld,
    output weights_progd, data_vec_progd, comp_res, comp_res_vld
  );
endinterface

// File: rtl/svm_multiclass_infer_ctrl.sv
// rtl/svm_multiclass_infer_ctrl.sv - SVM one-vs-rest inference sequencer (chunked dot products,
// saturating accumulate, bias, argmax); optional score write-back under SVM_SCORE_WB_EN.
module svm_multiclass_infer_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int LANES           = 32,
  parameter int NUM_CLASSES_MAX = 4,
  parameter int CLS_W           = $clog2(NUM_CLASSES_MAX) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    op_mode,
  input  logic [31:0]                   num_dim,
  input  logic [31:0]                   num_data_points,
  input  logic [CLS_W-1:0]              num_classes,
  input  logic                          cfg_done,
  output logic                          batch_done,
  svm_multiclass_infer_ctrl_if.master   bus
);

  localparam logic [3:0]  CMD_LD_WGHT = 4'd0;
  localparam logic [3:0]  CMD_LD_DATA = 4'd1;
  localparam logic [3:0]  CMD_WR_RES  = 4'd3;
  localparam logic [3:0]  CMD_LD_BIAS = 4'd5;
  localparam logic [2:0]  RSP_WGHT    = 3'd0;
  localparam logic [2:0]  RSP_DATA    = 3'd1;
  localparam logic [2:0]  RSP_WR      = 3'd2;
  localparam logic [2:0]  RSP_BIAS    = 3'd7;
  localparam logic [31:0] LANES_W     = 32'(LANES);

  typedef enum logic [3:0] {
    S_IDLE, S_LD_WGHT, S_LD_DATA, S_COMP, S_ACCUM, S_LD_BIAS, S_CLS_UPD, S_WR_RES
`ifdef SVM_SCORE_WB_EN
    , S_WR_SCORE
`endif
  } state_t;

  state_t                       state_q, state_d;
  logic [31:0]                  num_dim_q, num_dim_d;
  logic [31:0]                  npts_q, npts_d;
  logic [CLS_W-1:0]             ncls_q, ncls_d;
  logic [31:0]                  point_q, point_d;
  logic [CLS_W-1:0]             cls_q, cls_d;
  logic [31:0]                  dims_left_q, dims_left_d;
  logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] best_q, best_d;
  logic [CLS_W-1:0]             best_idx_q, best_idx_d;
  logic signed [DATA_WIDTH-1:0] res_q, res_d;
  logic                         wght_loaded_q, wght_loaded_d;
  logic                         batch_done_q, batch_done_d;
  logic                         clr_w_q, clr_w_d;
  logic                         clr_d_q, clr_d_d;

  logic [CLS_W-1:0]             ncls_in;
  logic [31:0]                  chunk_len;
  logic                         hold;
  logic                         last_point;
  logic                         last_cls;
  logic                         pt_adv;
  state_t                       start_state;
  logic signed [DATA_WIDTH-1:0] bias_ext;
  logic [31:0]                  res_word;

  function automatic logic signed [DATA_WIDTH-1:0] sat_add(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
      sat_add = s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      sat_add = s[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    ncls_in = num_classes;
    if (num_classes == '0)
      ncls_in = CLS_W'(1);
    else if (num_classes > CLS_W'(NUM_CLASSES_MAX))
      ncls_in = CLS_W'(NUM_CLASSES_MAX);
  end

  // A binary model that fits one chunk keeps its weights resident in the array for the whole batch.
  assign hold        = (num_dim_q <= LANES_W) && (num_dim_q != 32'd0) && (ncls_q == CLS_W'(1));
  assign chunk_len   = (dims_left_q < LANES_W) ? dims_left_q : LANES_W;
  assign last_point  = (point_q == npts_q - 32'd1);
  assign last_cls    = (cls_q == ncls_q - CLS_W'(1));
  assign start_state = (num_dim_q == 32'd0) ? S_LD_BIAS :
                       (hold && wght_loaded_q) ? S_LD_DATA : S_LD_WGHT;
  assign bias_ext    = DATA_WIDTH'($signed(bus.mem_resp_data));
  assign res_word    = (ncls_q == CLS_W'(1)) ? {31'd0, best_q[DATA_WIDTH-1]} : 32'(best_idx_q);

  always_comb begin
    state_d          = state_q;
    num_dim_d        = num_dim_q;
    npts_d           = npts_q;
    ncls_d           = ncls_q;
    point_d          = point_q;
    cls_d            = cls_q;
    dims_left_d      = dims_left_q;
    acc_d            = acc_q;
    best_d           = best_q;
    best_idx_d       = best_idx_q;
    res_d            = res_q;
    wght_loaded_d    = wght_loaded_q;
    batch_done_d     = 1'b0;
    clr_w_d          = 1'b0;
    clr_d_d          = 1'b0;
    pt_adv           = 1'b0;
    bus.mem_cmd_vld  = 1'b0;
    bus.mem_cmd      = 4'd0;
    bus.mem_cmd_data = 32'd0;
    bus.mem_cmd_cls  = '0;
    bus.comp_start   = 1'b0;
    bus.arr_wghtbar_data = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_done && op_mode == 2'd2) begin
          num_dim_d     = num_dim;
          npts_d        = num_data_points;
          ncls_d        = ncls_in;
          point_d       = 32'd0;
          cls_d         = '0;
          dims_left_d   = num_dim;
          acc_d         = '0;
          best_d        = '0;
          best_idx_d    = '0;
          wght_loaded_d = 1'b0;
          if (num_data_points == 32'd0)
            batch_done_d = 1'b1;
          else
            state_d = (num_dim == 32'd0) ? S_LD_BIAS : S_LD_WGHT;
        end
      end
      S_LD_WGHT: begin
        bus.mem_cmd_vld  = 1'b1;
        bus.mem_cmd      = CMD_LD_WGHT;
        bus.mem_cmd_data = chunk_len;
        bus.mem_cmd_cls  = cls_q;
        if (bus.mem_resp_vld && bus.mem_resp == RSP_WGHT && bus.weights_progd) begin
          wght_loaded_d = 1'b1;
          state_d       = S_LD_DATA;
        end
      end
      S_LD_DATA: begin
        bus.mem_cmd_vld      = 1'b1;
        bus.mem_cmd          = CMD_LD_DATA;
        bus.mem_cmd_data     = chunk_len;
        bus.mem_cmd_cls      = cls_q;
        bus.arr_wghtbar_data = 1'b1;
        if (bus.mem_resp_vld && bus.mem_resp == RSP_DATA && bus.data_vec_progd)
          state_d = S_COMP;
      end
      S_COMP: begin
        bus.comp_start = 1'b1;
        if (bus.comp_res_vld) begin
          res_d   = bus.comp_res;
          clr_d_d = 1'b1;
          clr_w_d = !hold || last_point;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d       = sat_add(acc_q, res_q);
        dims_left_d = dims_left_q - chunk_len;
        state_d     = (dims_left_q == chunk_len) ? S_LD_BIAS : S_LD_WGHT;
      end
      S_LD_BIAS: begin
        bus.mem_cmd_vld = 1'b1;
        bus.mem_cmd     = CMD_LD_BIAS;
        bus.mem_cmd_cls = cls_q;
        if (bus.mem_resp_vld && bus.mem_resp == RSP_BIAS) begin
          acc_d   = sat_add(acc_q, bias_ext);
          state_d = S_CLS_UPD;
        end
      end
      S_CLS_UPD: begin
        // Strict compare: on a tie the earlier (lower-index) class stays the winner.
        if (cls_q == '0 || acc_q > best_q) begin
          best_d     = acc_q;
          best_idx_d = cls_q;
        end
        acc_d = '0;
        if (last_cls) begin
          state_d = S_WR_RES;
        end else begin
          cls_d       = cls_q + CLS_W'(1);
          dims_left_d = num_dim_q;
          state_d     = start_state;
        end
      end
      S_WR_RES: begin
        bus.mem_cmd_vld  = 1'b1;
        bus.mem_cmd      = CMD_WR_RES;
        bus.mem_cmd_data = res_word;
        if (bus.mem_resp_vld && bus.mem_resp == RSP_WR) begin
`ifdef SVM_SCORE_WB_EN
          state_d = S_WR_SCORE;
`else
          pt_adv = 1'b1;
`endif
        end
      end
`ifdef SVM_SCORE_WB_EN
      S_WR_SCORE: begin
        bus.mem_cmd_vld  = 1'b1;
        bus.mem_cmd      = 4'd6;
        bus.mem_cmd_data = 32'(best_q);
        if (bus.mem_resp_vld && bus.mem_resp == RSP_WR)
          pt_adv = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (pt_adv) begin
      if (last_point) begin
        batch_done_d = 1'b1;
        state_d      = S_IDLE;
      end else begin
        point_d     = point_q + 32'd1;
        cls_d       = '0;
        dims_left_d = num_dim_q;
        state_d     = start_state;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      num_dim_q     <= '0;
      npts_q        <= '0;
      ncls_q        <= '0;
      point_q       <= '0;
      cls_q         <= '0;
      dims_left_q   <= '0;
      acc_q         <= '0;
      best_q        <= '0;
      best_idx_q    <= '0;
      res_q         <= '0;
      wght_loaded_q <= 1'b0;
      batch_done_q  <= 1'b0;
      clr_w_q       <= 1'b0;
      clr_d_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_dim_q     <= num_dim_d;
      npts_q        <= npts_d;
      ncls_q        <= ncls_d;
      point_q       <= point_d;
      cls_q         <= cls_d;
      dims_left_q   <= dims_left_d;
      acc_q         <= acc_d;
      best_q        <= best_d;
      best_idx_q    <= best_idx_d;
      res_q         <= res_d;
      wght_loaded_q <= wght_loaded_d;
      batch_done_q  <= batch_done_d;
      clr_w_q       <= clr_w_d;
      clr_d_q       <= clr_d_d;
    end
  end

  assign batch_done         = batch_done_q;
  assign bus.clear_weights  = clr_w_q;
  assign bus.clear_data_vec = clr_d_q;

endmodule

// File: tb/tb_svm_multiclass_infer_ctrl.sv
// tb/tb_svm_multiclass_infer_ctrl.sv - directed scoreboard bench for svm_multiclass_infer_ctrl
// (expected command stream built by a reference model; SVM_SCORE_WB_EN honoured if defined).
module tb_svm_multiclass_infer_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  op_mode;
  logic [31:0] num_dim;
  logic [31:0] num_data_points;
  logic [2:0]  num_classes;
  logic        cfg_done;
  logic        batch_done;

  int checks = 0;
  int errors = 0;

  logic [38:0] exp_q[$];
  int          comp_q[$];
  int          bias_q[$];
  int          vals[$];
  int          exp_clrw;

  svm_multiclass_infer_ctrl_if #(.DATA_WIDTH(32), .CLS_W(3)) bus ();

  svm_multiclass_infer_ctrl #(
    .DATA_WIDTH(32), .LANES(32), .NUM_CLASSES_MAX(4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .op_mode         (op_mode),
    .num_dim         (num_dim),
    .num_data_points (num_data_points),
    .num_classes     (num_classes),
    .cfg_done        (cfg_done),
    .batch_done      (batch_done),
    .bus             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({batch_done, bus.mem_cmd_vld, bus.mem_cmd, bus.mem_cmd_data, bus.mem_cmd_cls,
                bus.comp_start, bus.clear_weights, bus.clear_data_vec, bus.arr_wghtbar_data});
  endfunction

  function automatic longint sat32(input longint s);
    if (s > 64'sd2147483647)  return 64'sd2147483647;
    if (s < -64'sd2147483648) return -64'sd2147483648;
    return s;
  endfunction

  // Reference model: consumes vals (per point, per class: one value per chunk, then bias).
  task automatic plan(input int dim, input int ncls_in, input int npts);
    int     ncls;
    bit     hold;
    bit     wl;
    longint acc;
    longint best;
    int     bidx;
    int     left;
    int     len;
    int     v;
    ncls     = (ncls_in == 0) ? 1 : ((ncls_in > 4) ? 4 : ncls_in);
    hold     = (dim <= 32) && (dim != 0) && (ncls == 1);
    wl       = 0;
    exp_clrw = 0;
    for (int p = 0; p < npts; p++) begin
      best = 0;
      bidx = 0;
      for (int c = 0; c < ncls; c++) begin
        acc  = 0;
        left = dim;
        while (left > 0) begin
          len = (left < 32) ? left : 32;
          if (!(hold && wl)) exp_q.push_back({3'(c), 4'd0, 32'(len)});
          wl = 1;
          exp_q.push_back({3'(c), 4'd1, 32'(len)});
          v = vals.pop_front();
          comp_q.push_back(v);
          acc  = sat32(acc + longint'(v));
          left = left - len;
          if (!hold || p == npts - 1) exp_clrw++;
        end
        exp_q.push_back({3'(c), 4'd5, 32'd0});
        v = vals.pop_front();
        bias_q.push_back(v);
        acc = sat32(acc + longint'(v));
        if (c == 0 || acc > best) begin
          best = acc;
          bidx = c;
        end
      end
      exp_q.push_back({3'd0, 4'd3, (ncls == 1) ? ((best < 0) ? 32'd1 : 32'd0) : 32'(bidx)});
`ifdef SVM_SCORE_WB_EN
      exp_q.push_back({3'd0, 4'd6, 32'(best)});
`endif
    end
  endtask

  task automatic start(input logic [1:0] mode, input int dim, input int ncls, input int npts);
    @(negedge clk);
    op_mode         = mode;
    num_dim         = dim;
    num_classes     = 3'(ncls);
    num_data_points = npts;
    cfg_done        = 1'b1;
  endtask

  task automatic run_batch(input int budget, input bit spur_in, input bit abort_comp);
    int          n_clrw  = 0;
    bit          spur    = spur_in;
    bit          spur_chk = 0;
    bit          done    = 0;
    bit          aborted = 0;
    bit          noisy   = 0;
    logic [38:0] expv;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(negedge clk);
      cfg_done         = 1'b0;
      bus.mem_resp_vld = 1'b0;
      bus.comp_res_vld = 1'b0;
      if (bus.clear_weights) n_clrw++;
      if (batch_done) begin
        done = 1;
      end else if (bus.comp_start) begin
        if (abort_comp) begin
          rst = 1'b1;
          @(negedge clk);
          chk("post_rst_outputs", all_outs(), 64'd0);
          rst = 1'b0;
          for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            noisy |= bus.mem_cmd_vld | batch_done;
          end
          chk("abort_quiet", 64'(noisy), 64'd0);
          exp_q.delete();
          comp_q.delete();
          bias_q.delete();
          aborted = 1;
          done    = 1;
        end else begin
          bus.comp_res     = (comp_q.size() > 0) ? comp_q.pop_front() : 0;
          bus.comp_res_vld = 1'b1;
        end
      end else if (bus.mem_cmd_vld) begin
        if (spur_chk) begin
          chk("spurious_ignored", 64'({bus.mem_cmd_vld, bus.mem_cmd}), 64'({1'b1, 4'd0}));
          spur_chk = 0;
        end
        if (spur && bus.mem_cmd == 4'd0) begin
          spur             = 0;
          spur_chk         = 1;
          bus.mem_resp     = 3'd2;
          bus.mem_resp_vld = 1'b1;
        end else begin
          expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          chk("mem_cmd", 64'({bus.mem_cmd_cls, bus.mem_cmd, bus.mem_cmd_data}), 64'(expv));
          case (bus.mem_cmd)
            4'd0:    bus.mem_resp = 3'd0;
            4'd1:    bus.mem_resp = 3'd1;
            4'd5: begin
              bus.mem_resp      = 3'd7;
              bus.mem_resp_data = (bias_q.size() > 0) ? bias_q.pop_front() : 0;
            end
            default: bus.mem_resp = 3'd2;
          endcase
          bus.mem_resp_vld = 1'b1;
        end
      end
    end
    if (!aborted) begin
      chk("batch_done_seen", 64'(done), 64'd1);
      chk("cmds_left", 64'(exp_q.size()), 64'd0);
      chk("clear_weights_pulses", 64'(n_clrw), 64'(exp_clrw));
    end
  endtask

  initial begin
    bit seen;
    rst                = 1'b1;
    op_mode            = 2'd0;
    num_dim            = 32'd0;
    num_data_points    = 32'd0;
    num_classes        = 3'd0;
    cfg_done           = 1'b0;
    bus.mem_resp       = 3'd0;
    bus.mem_resp_data  = 32'd0;
    bus.mem_resp_vld   = 1'b0;
    bus.weights_progd  = 1'b1;
    bus.data_vec_progd = 1'b1;
    bus.comp_res       = 32'sd0;
    bus.comp_res_vld   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;

    // two chunks (32 + 8), negative result -> class 1
    vals = '{10, -25, 3};
    plan(40, 1, 1);
    start(2'd2, 40, 1, 1);
    run_batch(500, 0, 0);

    // three classes, scores 5, 9, 9 -> tie keeps index 1
    vals = '{2, 3, 4, 5, 9, 0};
    plan(16, 3, 1);
    start(2'd2, 16, 3, 1);
    run_batch(500, 0, 0);

    // positive and negative saturation
    vals = '{32'h7FFFFFF0, 32'h7FFFFFF0, 0};
    plan(64, 1, 1);
    start(2'd2, 64, 1, 1);
    run_batch(500, 0, 0);
    vals = '{-2147483632, -2147483632, 0};
    plan(64, 1, 1);
    start(2'd2, 64, 1, 1);
    run_batch(500, 0, 0);

    // empty batch
    start(2'd2, 8, 1, 0);
    @(negedge clk);
    cfg_done = 1'b0;
    chk("pts0_batch_done", 64'(batch_done), 64'd1);
    chk("pts0_no_cmd", 64'(bus.mem_cmd_vld), 64'd0);
    @(negedge clk);
    chk("pts0_pulse_width", 64'(batch_done), 64'd0);

    // weight-hold over three points
    vals = '{1, 2, -3, -4, 5, 6};
    plan(8, 1, 3);
    start(2'd2, 8, 1, 3);
    run_batch(800, 0, 0);

    // zero dims: bias only; class count clamped from 7 to 4
    vals = '{-4, 6, 6, -1};
    plan(0, 7, 1);
    start(2'd2, 0, 7, 1);
    run_batch(500, 0, 0);

    // score -7 (written back when score write-back is built in)
    vals = '{-10, 3};
    plan(8, 1, 1);
    start(2'd2, 8, 1, 1);
    run_batch(500, 0, 0);

    // wrong op_mode: start pulse ignored
    start(2'd1, 8, 1, 1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cfg_done = 1'b0;
      seen |= bus.mem_cmd_vld | batch_done;
    end
    chk("opmode_ignored", 64'(seen), 64'd0);

    // spurious WR_DONE during LD_WGHT, then reset in COMP
    vals = '{1, 2, 3, 4, 5, 6};
    plan(40, 1, 2);
    start(2'd2, 40, 1, 2);
    run_batch(500, 1, 1);

    // sequencer usable again after abort
    vals = '{7, -2};
    plan(8, 1, 1);
    start(2'd2, 8, 1, 1);
    run_batch(500, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
